// File: rtl/vscale_hasti_arbiter.sv
// Two-master HASTI (AHB-Lite) arbiter in front of a single slave port (SRAM p0).
// Each master owns one capture slot; the slave sees at most one NONSEQ per ready cycle.
module vscale_hasti_arbiter (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [31:0] m0_haddr,
    input  logic        m0_hwrite,
    input  logic [2:0]  m0_hsize,
    input  logic [2:0]  m0_hburst,
    input  logic        m0_hmastlock,
    input  logic [3:0]  m0_hprot,
    input  logic [1:0]  m0_htrans,
    input  logic [31:0] m0_hwdata,
    output logic [31:0] m0_hrdata,
    output logic        m0_hready,
    output logic        m0_hresp,
    input  logic [31:0] m1_haddr,
    input  logic        m1_hwrite,
    input  logic [2:0]  m1_hsize,
    input  logic [2:0]  m1_hburst,
    input  logic        m1_hmastlock,
    input  logic [3:0]  m1_hprot,
    input  logic [1:0]  m1_htrans,
    input  logic [31:0] m1_hwdata,
    output logic [31:0] m1_hrdata,
    output logic        m1_hready,
    output logic        m1_hresp,
    output logic [31:0] s_haddr,
    output logic        s_hwrite,
    output logic [2:0]  s_hsize,
    output logic [2:0]  s_hburst,
    output logic        s_hmastlock,
    output logic [3:0]  s_hprot,
    output logic [1:0]  s_htrans,
    output logic [31:0] s_hwdata,
    input  logic [31:0] s_hrdata,
    input  logic        s_hready,
    input  logic        s_hresp
);
    // Widths follow the HASTI constants: ADDR/BUS 32, SIZE/BURST 3, PROT 4, TRANS 2, RESP 1.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_DATA} state_e;

    typedef struct packed {
        logic [31:0] haddr;
        logic        hwrite;
        logic [2:0]  hsize;
        logic [2:0]  hburst;
        logic        hmastlock;
        logic [3:0]  hprot;
    } addr_ph_t;

    addr_ph_t   m_req    [2];
    logic [1:0] m_htrans [2];
    state_e     state_q  [2];
    addr_ph_t   cap_q    [2];
    addr_ph_t   issued_q;
    addr_ph_t   s_req;
    logic       tie_last_q, tie_last_d;
    logic       own_vld_q, own_vld_d;
    logic       own_id_q, own_id_d;
    logic [1:0] rdy, pend, capture;
    logic       issue, gnt;

    assign m_req[0]    = {m0_haddr, m0_hwrite, m0_hsize, m0_hburst, m0_hmastlock, m0_hprot};
    assign m_req[1]    = {m1_haddr, m1_hwrite, m1_hsize, m1_hburst, m1_hmastlock, m1_hprot};
    assign m_htrans[0] = m0_htrans;
    assign m_htrans[1] = m1_htrans;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rdy[i]     = (state_q[i] == ST_IDLE) || ((state_q[i] == ST_DATA) && s_hready);
            pend[i]    = (state_q[i] == ST_PEND);
            capture[i] = rdy[i] && ((m_htrans[i] == HTRANS_NONSEQ) || (m_htrans[i] == HTRANS_SEQ));
        end
        issue = s_hready && (pend != 2'b00);
        gnt   = (pend == 2'b11) ? ~tie_last_q : pend[1];
    end

    // The tie pointer only moves on contention, so alternation is between ties.
    always_comb begin
        own_vld_d  = own_vld_q;
        own_id_d   = own_id_q;
        tie_last_d = tie_last_q;
        if (issue) begin
            own_vld_d = 1'b1;
            own_id_d  = gnt;
            if (pend == 2'b11) tie_last_d = gnt;
        end else if (s_hready) begin
            own_vld_d = 1'b0;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= ST_IDLE;
                cap_q[i]   <= '0;
            end
            issued_q   <= '0;
            tie_last_q <= 1'b1;
            own_vld_q  <= 1'b0;
            own_id_q   <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (capture[i]) begin
                    state_q[i] <= ST_PEND;
                    cap_q[i]   <= m_req[i];
                end else if (issue && (gnt == 1'(i))) begin
                    state_q[i] <= ST_DATA;
                end else if ((state_q[i] == ST_DATA) && s_hready) begin
                    state_q[i] <= ST_IDLE;
                end
            end
            if (issue) issued_q <= cap_q[gnt];
            tie_last_q <= tie_last_d;
            own_vld_q  <= own_vld_d;
            own_id_q   <= own_id_d;
        end
    end

    // Address/control hold their last issued value whenever nothing is issued.
    assign s_req       = issue ? cap_q[gnt] : issued_q;
    assign s_haddr     = s_req.haddr;
    assign s_hwrite    = s_req.hwrite;
    assign s_hsize     = s_req.hsize;
    assign s_hburst    = s_req.hburst;
    assign s_hmastlock = s_req.hmastlock;
    assign s_hprot     = s_req.hprot;
    assign s_htrans    = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign s_hwdata    = !own_vld_q ? 32'd0 : (own_id_q ? m1_hwdata : m0_hwdata);

    assign m0_hrdata = s_hrdata;
    assign m1_hrdata = s_hrdata;
    assign m0_hready = rdy[0];
    assign m1_hready = rdy[1];
    assign m0_hresp  = own_vld_q && !own_id_q && s_hresp;
    assign m1_hresp  = own_vld_q && own_id_q && s_hresp;

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Bench for vscale_hasti_arbiter: directed scenarios, then random two-master traffic
// against a transaction-level model with a reference memory.
module tb_vscale_hasti_arbiter;
  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  logic [31:0] m_haddr [2];
  logic        m_hwrite [2];
  logic [2:0]  m_hsize [2];
  logic [2:0]  m_hburst [2];
  logic        m_hmastlock [2];
  logic [3:0]  m_hprot [2];
  logic [1:0]  m_htrans [2];
  logic [31:0] m_hwdata [2];
  logic [1:0][31:0] m_hrdata;
  logic [1:0]  m_hready, m_hresp;
  logic [31:0] s_haddr, s_hwdata, s_hrdata;
  logic        s_hwrite, s_hmastlock, s_hready, s_hresp;
  logic [2:0]  s_hsize, s_hburst;
  logic [3:0]  s_hprot;
  logic [1:0]  s_htrans;

  int errors = 0;
  int checks = 0;

  vscale_hasti_arbiter dut (
    .hclk(hclk), .hresetn(hresetn),
    .m0_haddr(m_haddr[0]), .m0_hwrite(m_hwrite[0]), .m0_hsize(m_hsize[0]), .m0_hburst(m_hburst[0]),
    .m0_hmastlock(m_hmastlock[0]), .m0_hprot(m_hprot[0]), .m0_htrans(m_htrans[0]), .m0_hwdata(m_hwdata[0]),
    .m0_hrdata(m_hrdata[0]), .m0_hready(m_hready[0]), .m0_hresp(m_hresp[0]),
    .m1_haddr(m_haddr[1]), .m1_hwrite(m_hwrite[1]), .m1_hsize(m_hsize[1]), .m1_hburst(m_hburst[1]),
    .m1_hmastlock(m_hmastlock[1]), .m1_hprot(m_hprot[1]), .m1_htrans(m_htrans[1]), .m1_hwdata(m_hwdata[1]),
    .m1_hrdata(m_hrdata[1]), .m1_hready(m_hready[1]), .m1_hresp(m_hresp[1]),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize), .s_hburst(s_hburst),
    .s_hmastlock(s_hmastlock), .s_hprot(s_hprot), .s_htrans(s_htrans), .s_hwdata(s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  always #5 hclk = ~hclk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic smp();
    @(negedge hclk);
  endtask

  task automatic drv(input int m, input logic [1:0] tr, input logic [31:0] a, input logic wr);
    m_htrans[m] = tr;
    m_haddr[m]  = a;
    m_hwrite[m] = wr;
  endtask

  // transaction-level model state
  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic        lock;
    logic [3:0]  prot;
    logic [1:0]  trans;
    logic [31:0] wdata;
  } rq_t;

  rq_t  pres [2];
  bit   pres_v [2];
  rq_t  outq [2];
  int   mst [2];          // 0 nothing outstanding, 1 captured/waiting, 2 in slave data phase
  int   last_tie = 1;
  bit   dp_v = 0;
  int   dp_id = 0;
  logic [31:0] ref_mem [16];
  logic [31:0] slv_mem [16];
  bit   sl_act = 0;
  bit   sl_wr = 0;
  logic [31:0] sl_addr = '0;
  int   accepted = 0;
  int   issued_cnt = 0;

  function automatic bit busy();
    return pres_v[0] || pres_v[1] || (mst[0] != 0) || (mst[1] != 0);
  endfunction

  task automatic rnd_cycle(input bit stop);
    bit rdy [2];
    int w;
    cyc();
    for (int m = 0; m < 2; m++) begin
      if (!pres_v[m] && !stop && ($urandom_range(0, 2) == 0)) begin
        pres[m].addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        pres[m].wr    = 1'($urandom_range(0, 1));
        pres[m].size  = 3'($urandom_range(0, 2));
        pres[m].burst = 3'($urandom_range(0, 7));
        pres[m].lock  = 1'($urandom_range(0, 1));
        pres[m].prot  = 4'($urandom_range(0, 15));
        pres[m].trans = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
        pres[m].wdata = $urandom();
        pres_v[m] = 1;
      end
      m_htrans[m] = pres_v[m] ? pres[m].trans : 2'($urandom_range(0, 1));
      if (pres_v[m]) begin
        m_haddr[m] = pres[m].addr;   m_hwrite[m] = pres[m].wr;
        m_hsize[m] = pres[m].size;   m_hburst[m] = pres[m].burst;
        m_hmastlock[m] = pres[m].lock; m_hprot[m] = pres[m].prot;
      end else begin
        m_haddr[m] = $urandom();
      end
      m_hwdata[m] = (mst[m] != 0) ? outq[m].wdata : $urandom();
    end
    s_hready = ($urandom_range(0, 3) != 0);
    s_hresp  = ($urandom_range(0, 7) == 0);
    s_hrdata = (sl_act && !sl_wr) ? slv_mem[sl_addr[5:2]] : $urandom();
    smp();

    for (int m = 0; m < 2; m++) begin
      rdy[m] = (mst[m] == 0) || ((mst[m] == 2) && s_hready);
      check("rnd_hready", 32'(m_hready[m]), 32'(rdy[m]));
      check("rnd_hresp", 32'(m_hresp[m]), (dp_v && dp_id == m) ? 32'(s_hresp) : 32'd0);
    end

    w = -1;
    if (s_hready) begin
      if (mst[0] == 1 && mst[1] == 1) w = 1 - last_tie;
      else if (mst[0] == 1) w = 0;
      else if (mst[1] == 1) w = 1;
    end
    check("rnd_htrans", 32'(s_htrans), (w >= 0) ? 32'd2 : 32'd0);
    if (w >= 0) begin
      check("rnd_haddr", s_haddr, outq[w].addr);
      check("rnd_hctrl", 32'({s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot}),
            32'({outq[w].wr, outq[w].size, outq[w].burst, outq[w].lock, outq[w].prot}));
    end
    if (!dp_v) check("rnd_hwdata_idle", s_hwdata, 32'd0);
    else if (outq[dp_id].wr) check("rnd_hwdata", s_hwdata, outq[dp_id].wdata);

    // what the coming edge does: completion, issue, capture
    if (s_hready && dp_v) begin
      if (outq[dp_id].wr) ref_mem[outq[dp_id].addr[5:2]] = outq[dp_id].wdata;
      else check("rnd_hrdata", m_hrdata[dp_id], ref_mem[outq[dp_id].addr[5:2]]);
      mst[dp_id] = 0;
    end
    if (w >= 0) begin
      if (mst[0] == 1 && mst[1] == 1) last_tie = w;
      mst[w] = 2;
    end
    if (s_hready) begin
      dp_v  = (w >= 0);
      dp_id = (w >= 0) ? w : 0;
    end
    for (int m = 0; m < 2; m++) begin
      if (rdy[m] && pres_v[m]) begin
        outq[m] = pres[m];
        mst[m] = 1;
        pres_v[m] = 0;
        accepted++;
      end
    end

    // behavioural slave memory, driven purely from the slave-port pins
    if (s_hready) begin
      if (sl_act && sl_wr) slv_mem[sl_addr[5:2]] = s_hwdata;
      sl_act  = (s_htrans == 2'b10);
      sl_addr = s_haddr;
      sl_wr   = s_hwrite;
      if (sl_act) issued_cnt++;
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      drv(m, 2'b00, 32'd0, 1'b0);
      m_hsize[m] = 3'd2; m_hburst[m] = 3'd0; m_hmastlock[m] = 1'b0; m_hprot[m] = 4'd3;
      m_hwdata[m] = 32'd0; pres_v[m] = 0; mst[m] = 0;
    end
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom();
      slv_mem[i] = ref_mem[i];
    end
    s_hready = 1'b1; s_hresp = 1'b1; s_hrdata = 32'd0;
    #3;
    check("rst_m0_hready", 32'(m_hready[0]), 32'd1);
    check("rst_m1_hready", 32'(m_hready[1]), 32'd1);
    check("rst_s_htrans", 32'(s_htrans), 32'd0);
    check("rst_s_haddr", s_haddr, 32'd0);
    check("rst_hresp", 32'(m_hresp), 32'd0);
    s_hresp = 1'b0;
    cyc(); cyc();
    hresetn = 1'b1;

    // single write from m0, zero-wait slave
    cyc(); drv(0, 2'b10, 32'h100, 1'b1);
    smp(); check("wr_t0_m0_hready", 32'(m_hready[0]), 32'd1);
    check("wr_t0_s_htrans", 32'(s_htrans), 32'd0);
    cyc(); m_htrans[0] = 2'b00; m_hwdata[0] = 32'hDEADBEEF;
    smp(); check("wr_t1_s_htrans", 32'(s_htrans), 32'd2);
    check("wr_t1_s_haddr", s_haddr, 32'h100);
    check("wr_t1_s_hwrite", 32'(s_hwrite), 32'd1);
    check("wr_t1_m0_hready", 32'(m_hready[0]), 32'd0);
    cyc(); smp();
    check("wr_t2_s_hwdata", s_hwdata, 32'hDEADBEEF);
    check("wr_t2_m0_hready", 32'(m_hready[0]), 32'd1);
    check("wr_t2_s_htrans", 32'(s_htrans), 32'd0);
    check("wr_t2_s_haddr_hold", s_haddr, 32'h100);
    cyc(); smp(); check("wr_t3_s_hwdata", s_hwdata, 32'd0);

    // two ties: m0 wins the first, m1 the second
    cyc(); drv(0, 2'b10, 32'h10, 1'b0); drv(1, 2'b10, 32'h20, 1'b0);
    cyc(); m_htrans[0] = 2'b00; m_htrans[1] = 2'b00;
    smp(); check("tie1_first_htrans", 32'(s_htrans), 32'd2);
    check("tie1_first_haddr", s_haddr, 32'h10);
    cyc(); smp(); check("tie1_second_haddr", s_haddr, 32'h20);
    check("tie1_second_htrans", 32'(s_htrans), 32'd2);
    check("tie1_m0_done", 32'(m_hready[0]), 32'd1);
    check("tie1_m1_wait", 32'(m_hready[1]), 32'd0);
    cyc(); smp(); check("tie1_m1_done", 32'(m_hready[1]), 32'd1);
    check("tie1_idle", 32'(s_htrans), 32'd0);
    cyc(); drv(0, 2'b11, 32'h30, 1'b0); drv(1, 2'b10, 32'h40, 1'b0);
    cyc(); m_htrans[0] = 2'b00; m_htrans[1] = 2'b00;
    smp(); check("tie2_first_haddr", s_haddr, 32'h40);
    check("tie2_first_htrans", 32'(s_htrans), 32'd2);
    cyc(); smp(); check("tie2_second_haddr", s_haddr, 32'h30);
    check("tie2_seq_as_nonseq", 32'(s_htrans), 32'd2);
    cyc();

    // m1 read stalled 3 cycles; m0 queues behind it and goes out on release
    cyc(); drv(1, 2'b10, 32'h200, 1'b0);
    cyc(); m_htrans[1] = 2'b00;
    smp(); check("stall_issue_haddr", s_haddr, 32'h200);
    check("stall_issue_htrans", 32'(s_htrans), 32'd2);
    cyc(); s_hready = 1'b0; s_hresp = 1'b1; drv(0, 2'b10, 32'h300, 1'b0);
    smp(); check("stall0_m1_hready", 32'(m_hready[1]), 32'd0);
    check("stall0_m0_hready", 32'(m_hready[0]), 32'd1);
    check("stall0_m1_hresp", 32'(m_hresp[1]), 32'd1);
    check("stall0_m0_hresp", 32'(m_hresp[0]), 32'd0);
    for (int k = 1; k < 3; k++) begin
      cyc(); m_htrans[0] = 2'b00;
      smp(); check("stall_m1_hready", 32'(m_hready[1]), 32'd0);
      check("stall_m0_hready", 32'(m_hready[0]), 32'd0);
      check("stall_haddr", s_haddr, 32'h200);
      check("stall_htrans", 32'(s_htrans), 32'd0);
      check("stall_m1_hresp", 32'(m_hresp[1]), 32'd1);
    end
    cyc(); s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = 32'hCAFE0200;
    smp(); check("rel_m1_hready", 32'(m_hready[1]), 32'd1);
    check("rel_m1_hrdata", m_hrdata[1], 32'hCAFE0200);
    check("rel_b2b_htrans", 32'(s_htrans), 32'd2);
    check("rel_b2b_haddr", s_haddr, 32'h300);
    cyc(); s_hresp = 1'b1;
    smp(); check("err_m0_hresp", 32'(m_hresp[0]), 32'd1);
    check("err_m1_hresp", 32'(m_hresp[1]), 32'd0);
    check("err_m0_hready", 32'(m_hready[0]), 32'd1);

    // reset while m1 is pending
    cyc(); s_hresp = 1'b0; s_hready = 1'b0; drv(1, 2'b10, 32'h240, 1'b1);
    cyc(); m_htrans[1] = 2'b00;
    smp(); check("pend_m1_hready", 32'(m_hready[1]), 32'd0);
    check("pend_haddr_hold", s_haddr, 32'h300);
    hresetn = 1'b0;
    #1;
    check("arst_s_htrans", 32'(s_htrans), 32'd0);
    check("arst_s_haddr", s_haddr, 32'd0);
    check("arst_m1_hready", 32'(m_hready[1]), 32'd1);
    check("arst_m0_hready", 32'(m_hready[0]), 32'd1);
    cyc(); hresetn = 1'b1; s_hready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp(); check("post_rst_htrans", 32'(s_htrans), 32'd0);
      check("post_rst_m1_hready", 32'(m_hready[1]), 32'd1);
      cyc();
    end

    // random traffic against the model
    for (int k = 0; k < 1500; k++) rnd_cycle(1'b0);
    for (int k = 0; k < 60 && busy(); k++) rnd_cycle(1'b1);
    check("drain_idle", 32'(busy()), 32'd0);
    check("xfer_count", issued_cnt, accepted);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vscale_hasti_arbiter.md
VSCALE_HASTI_ARBITER -- requirements
Module: vscale_hasti_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL come from vscale_hasti_constants.vh (ADDR 32, BUS 32, SIZE 3, BURST 3, PROT 4, TRANS 2, RESP 1).
REQ-002 hclk  in  1  single clock; all state updates on its rising edge.
REQ-003 hresetn  in  1  reset, asynchronous assert, active-low.
REQ-004 mN_haddr, mN_hwrite, mN_hsize, mN_hburst, mN_hmastlock, mN_hprot, mN_htrans, mN_hwdata  in  (HASTI widths)  master N (N=0,1) address/data-phase signals; each master is a core dmem port.
REQ-005 mN_hrdata  out  32  read data to master N.
REQ-006 mN_hready  out  1  transfer-done / address-accept to master N.
REQ-007 mN_hresp  out  1  response to master N.
REQ-008 s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot, s_htrans, s_hwdata  out  (HASTI widths)  single slave port, wired to SRAM p0.
REQ-009 s_hrdata  in  32;  s_hready  in  1;  s_hresp  in  1  slave return signals.

Function
REQ-010 Per master, a 3-state FSM SHALL exist: IDLE, PEND (address captured, not yet issued to slave), DATA (issued, slave data phase in progress).
REQ-011 mN_hready SHALL be 1 in IDLE, 0 in PEND, s_hready in DATA.
REQ-012 An address SHALL be captured when mN_hready=1 and mN_htrans[1]=1 (NONSEQ/SEQ); haddr, hwrite, hsize, hburst, hmastlock, hprot SHALL be registered; FSM goes to PEND.
REQ-013 IDLE/BUSY htrans SHALL not be captured; FSM stays in or returns to IDLE.
REQ-014 DATA with s_hready=1 SHALL go to PEND if a new address is captured that cycle, else IDLE.
REQ-015 In a cycle with s_hready=1, at most one PEND master SHALL be issued: s_htrans=NONSEQ (2'b10), s_haddr and controls from its capture register; that master goes to DATA next edge.
REQ-016 With no PEND master, or s_hready=0, s_htrans SHALL be IDLE (2'b00); other s_* address outputs SHALL hold their last value.
REQ-017 SEQ from a master SHALL be forwarded as NONSEQ; s_hburst SHALL be forwarded unchanged.
REQ-018 Both PEND: grant SHALL go to the master not granted last; last-grant register resets to 1, so m0 wins the first tie.
REQ-019 A data-owner register (valid, id) SHALL be set on issue and cleared on s_hready=1 with no new issue; s_hwdata SHALL mux from the owner's mN_hwdata (0 if none).
REQ-020 s_hrdata SHALL be broadcast to both masters; mN_hresp SHALL equal s_hresp when N is data owner, else 0.
REQ-021 Each master SHALL have at most one outstanding transfer; minimum latency SHALL be address cycle T, issue T+1, master hready=1 at T+2 (one added wait state with zero-wait slave).
REQ-022 A master issued in the same cycle the other master's data phase completes SHALL be legal (back-to-back pipelining, no bubble).
REQ-023 While s_hready=0, the issued address and owner SHALL be held; no new issue, no grant change.

Reset
REQ-024 Asserting hresetn=0 SHALL immediately force: both FSMs IDLE, owner invalid, last-grant=1, capture registers 0, s_htrans=IDLE, s_haddr=0, m0/m1_hready=1, mN_hresp=0.
REQ-025 Reset mid-transfer SHALL discard captured and in-flight transfers without replay; the first capture after deassertion SHALL behave as from power-up.

Verification
REQ-026 m0 NONSEQ write 0x100 data 0xDEADBEEF, m1 idle, zero-wait slave -> s_htrans=2 with s_haddr=0x100 at T+1, s_hwdata=0xDEADBEEF at T+2, m0_hready 0 at T+1, 1 at T+2.
REQ-027 m0 and m1 NONSEQ same cycle after reset -> m0 issued first, m1 next cycle; second tie -> m1 first.
REQ-028 Slave holds s_hready=0 for 3 cycles during m1 read of 0x200 -> s_haddr/owner stable, m1_hready=0 throughout, m1_hrdata valid on release cycle.
REQ-029 m0 back-to-back reads 0x0,0x4 while m1 writes 0x8 -> three slave transfers, no lost or duplicated beat, each master gets its own data.
REQ-030 hresetn pulsed low while m1 in PEND -> outputs at reset values same cycle, no s_htrans=2 for that address after release.
REQ-031 s_hresp=1 during m0 data phase -> m0_hresp=1, m1_hresp=0.
